// File: rtl/seq111_scan_ctrl.sv
// Feeds an accepted W-bit word MSB-first into a 111 Moore detector and returns the per-word detection count.
// Word latency W+1 cycles to cnt_valid; din_ready only in IDLE, and DONE holds everything until cnt_ready.
module seq111_scan_ctrl #(
  parameter int W  = 8,
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [W-1:0]  din,
  input  logic          din_valid,
  output logic          din_ready,
  input  logic          carry,
  output logic [CW-1:0] cnt,
  output logic          cnt_valid,
  input  logic          cnt_ready,
  output logic          z,
  output logic [1:0]    det_state,
  output logic          busy
);

  localparam int BW = (W > 1) ? $clog2(W) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} ctrl_t;
  typedef enum logic [1:0] {S0 = 2'b00, S1 = 2'b01, S2 = 2'b10, S3 = 2'b11} det_t;

  ctrl_t          state;
  det_t           det;
  det_t           det_nxt;
  logic [W-1:0]   sreg;
  logic [BW-1:0]  bit_idx;

  // Next detector state for the bit currently at the shift register MSB.
  always_comb begin
    det_nxt = S0;
    if (sreg[W-1]) begin
      case (det)
        S0:      det_nxt = S1;
        S1:      det_nxt = S2;
        S2:      det_nxt = S3;
        default: det_nxt = S1;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      det     <= S0;
      z       <= 1'b0;
      sreg    <= '0;
      bit_idx <= '0;
      cnt     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (din_valid) begin
            sreg    <= din;
            bit_idx <= '0;
            cnt     <= '0;
            if (!carry) begin
              det <= S0;
              z   <= 1'b0;
            end
            state <= SHIFT;
          end
        end
        SHIFT: begin
          det     <= det_nxt;
          z       <= (det_nxt == S3);
          if ((det_nxt == S3) && (cnt != '1))
            cnt <= cnt + 1'b1;
          sreg    <= {sreg[W-2:0], 1'b0};
          bit_idx <= bit_idx + 1'b1;
          if (bit_idx == BW'(W - 1))
            state <= DONE;
        end
        DONE: begin
          if (cnt_ready)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign din_ready = (state == IDLE);
  assign cnt_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign det_state = det;

endmodule

// File: doc/seq111_scan_ctrl.md
# seq111_scan_ctrl

Controller that sequences the team's "111" Moore sequence detector over parallel data. It accepts a W-bit word with a valid/ready handshake and feeds it MSB-first, one bit per clock, into an embedded 4-state 111 detector. It counts detections for the word and returns the count on a second valid/ready handshake. It sits between a word-oriented producer and any consumer that needs per-word pattern counts.

## Interface
Parameters:
- W, 8, data word width; must be ≥ 3.
- CW, 4, count width; must be ≥ clog2(W/3 + 2).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-low.
- din  input  W  word to scan; bit W-1 is scanned first.
- din_valid  input  1  producer has a word on din.
- din_ready  output  1  controller can accept a word; high exactly in IDLE.
- carry  input  1  sampled at word accept. 1: detector keeps its state from the previous word. 0: detector restarts at s0.
- cnt  output  CW  number of detections in the last word.
- cnt_valid  output  1  cnt is valid.
- cnt_ready  input  1  consumer accepts cnt.
- z  output  1  detector Moore output; 1 iff detector state is s3.
- det_state  output  2  detector state: s0=00, s1=01, s2=10, s3=11.
- busy  output  1  high in SHIFT or DONE.

## Operation
- Detector transitions, with x being the scanned bit:
  - x=0 from any state goes to s0.
  - x=1: s0→s1, s1→s2, s2→s3, s3→s1.
  - Runs of 1s therefore detect non-overlapping: "111111" gives 2 detections, "1111" gives 1.
- Controller FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - din_ready=1.
  - On din_valid & din_ready:
    - capture din into the shift register;
    - latch carry; if carry=0, force the detector state to s0;
    - clear the bit counter and cnt;
    - go to SHIFT.
  - Otherwise the detector holds its state.
- SHIFT:
  - Each cycle, x = shift register MSB.
  - The detector advances one step and the shift register shifts left.
  - cnt increments when the next state is s3. It saturates at 2^CW−1, which is unreachable for legal parameters.
  - After the bit with counter value W−1, go to DONE.
- DONE:
  - cnt_valid=1 and cnt is held stable.
  - When cnt_ready=1, go to IDLE and drop cnt_valid.
  - The detector holds its state throughout DONE.
- din_valid outside IDLE is ignored: no capture, no error. A din change while valid and not ready is legal; only the captured value matters.
- Reset (rst=0), asynchronous and effective immediately, including mid-SHIFT or mid-DONE:
  - FSM=IDLE, detector=s0, shift register=0, bit counter=0.
  - cnt=0, cnt_valid=0, z=0, det_state=00, busy=0.
  - din_ready=1, but no word is captured while rst=0.
  - Operation resumes on the first rising edge after rst returns high.

## Timing
- E0 is the accept edge. Bit i (i=0..W−1) is consumed at edge E0+1+i.
- FSM enters DONE at edge E0+W; cnt_valid is high in the cycle after E0+W.
- z and det_state are registered. They reflect bits consumed up to and including the last edge, so z rises the cycle after the edge that consumed the third 1.
- If cnt_ready is already high, DONE lasts 1 cycle and din_ready returns at E0+W+1. Throughput is 1 word per W+2 cycles.
- If cnt_ready is held low, DONE lasts indefinitely with cnt, z and det_state stable.
- All outputs are driven directly from flops or from a decode of the FSM state only; there are no combinational paths from inputs to outputs.

## Test plan
- Reset: drive rst=0 at any time → next cycle shows cnt=0, cnt_valid=0, z=0, det_state=00, busy=0, din_ready=1. With rst=0 and din_valid=1, nothing is captured.
- din=8'b1110_0000, carry=0, cnt_ready=1 → z=1 for exactly the one cycle following E0+3, cnt=1 with cnt_valid high after E0+8, final det_state=00, din_ready back at E0+9.
- din=8'hFF, carry=0 → det_state follows 01,10,11,01,10,11,01,10, cnt=2, z high for 2 separate single cycles.
- After the 8'hFF word (detector left in s2), send din=8'b1000_0000 with carry=1 → cnt=1 (detection on the first bit). Repeat the same two words with carry=0 on the second → cnt=0.
- Hold cnt_ready=0 for 5 cycles in DONE → cnt_valid, cnt, z and det_state stable; din_ready=0; a din_valid pulse is ignored. Raising cnt_ready returns the FSM to IDLE after 1 edge.
- Assert rst=0 mid-SHIFT after 4 bits of 8'hFF → immediate reset values. Then send 8'b0111_0000 with carry=1 → cnt=1 (the detector started from s0).
